// File: rtl/mem_bridge.sv
// Single-beat bridge from a main-bus read/write request to a req/ack memory port.
// Includes an ack timeout, illegal-request detection and a held read-data register.
module mem_bridge #(
   parameter int WIDTH_AX   = 16,
   parameter int WIDTH_MAIN = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [WIDTH_AX-1:0]   addr_in,
   input  logic [WIDTH_MAIN-1:0] main_in,
   input  logic                  assert_main,
   output logic [WIDTH_MAIN-1:0] main_out,
   output logic                  main_en,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [WIDTH_AX-1:0]   mem_addr,
   output logic [WIDTH_MAIN-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_req,
   input  logic [WIDTH_MAIN-1:0] mem_rdata,
   input  logic                  mem_ack
);

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE,
      S_ERR
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [WIDTH_AX-1:0]   addr_q, addr_d;
   logic [WIDTH_MAIN-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [WIDTH_MAIN-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (mem_read && mem_write) begin
               state_d = S_ERR;
            end else if (mem_read || mem_write) begin
               addr_d  = addr_in;
               wdata_d = main_in;
               we_d    = mem_write;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // ack wins over a timeout in the same cycle
            if (mem_ack) begin
               if (!we_q) rdata_d = mem_rdata;
               state_d = S_DONE;
            end else if (cnt_q == TMO) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         S_ERR: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_req   = (state_q == S_REQ);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = we_q;
   assign main_en   = assert_main;
   assign main_out  = assert_main ? rdata_q : '0;

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: directed cases then random transactions
// checked against a transaction-level reference model.
module tb_mem_bridge;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [15:0] addr_in;
   logic [7:0]  main_in;
   logic        assert_main;
   logic [7:0]  main_out;
   logic        main_en, busy, done, err;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we, mem_req;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [7:0]  exp_rd;
   logic [15:0] exp_addr;
   logic [7:0]  exp_wd;
   logic        exp_we;

   mem_bridge #(
      .WIDTH_AX(16),
      .WIDTH_MAIN(8),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .addr_in(addr_in),
      .main_in(main_in),
      .assert_main(assert_main),
      .main_out(main_out),
      .main_en(main_en),
      .busy(busy),
      .done(done),
      .err(err),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we(mem_we),
      .mem_req(mem_req),
      .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_main(input logic am);
      assert_main = am;
      #1;
      chk("main_en", 32'(main_en), 32'(am));
      chk("main_out", 32'(main_out),
          am ? 32'(exp_rd) : 32'd0);
   endtask

   // kind: 0 read, 1 write, 2 illegal (both)
   task automatic xact(input int kind,
                       input logic [15:0] a,
                       input logic [7:0] wd,
                       input int dly,
                       input logic [7:0] rd);
      int  nreq;
      bit  ok;
      mem_read  = (kind != 1);
      mem_write = (kind != 0);
      addr_in   = a;
      main_in   = wd;
      step();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_in   = 16'($urandom);
      main_in   = 8'($urandom);
      if (kind == 2) begin
         chk("ill_err", 32'(err), 32'd1);
         chk("ill_req", 32'(mem_req), 32'd0);
         chk("ill_busy", 32'(busy), 32'd1);
      end else begin
         exp_addr = a;
         exp_wd   = wd;
         exp_we   = (kind == 1);
         nreq = 0;
         ok   = 1'b0;
         for (int k = 0; k <= TMO; k++) begin
            chk("req", 32'(mem_req), 32'd1);
            chk("addr", 32'(mem_addr), 32'(exp_addr));
            chk("we", 32'(mem_we), 32'(exp_we));
            chk("wdata", 32'(mem_wdata), 32'(exp_wd));
            nreq++;
            mem_ack   = (k == dly);
            mem_rdata = (k == dly) ? rd : 8'($urandom);
            mem_read  = 1'($urandom);
            mem_write = 1'($urandom);
            step();
            mem_ack   = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            if (k == dly) begin
               ok = 1'b1;
               break;
            end
         end
         chk("nreq", 32'(nreq),
             32'((dly <= TMO) ? dly + 1 : TMO + 1));
         if (ok && kind == 0) exp_rd = rd;
         chk("done", 32'(done), 32'(ok));
         chk("err", 32'(err), 32'(!ok));
         chk("req_off", 32'(mem_req), 32'd0);
         chk("busy_end", 32'(busy), 32'd1);
      end
      // stray ack and requests in DONE/ERR are ignored
      mem_ack   = 1'($urandom);
      mem_read  = 1'($urandom);
      mem_write = 1'($urandom);
      step();
      mem_ack   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_err", 32'(err), 32'd0);
      chk("idle_req", 32'(mem_req), 32'd0);
      chk("hold_addr", 32'(mem_addr), 32'(exp_addr));
      chk("hold_wd", 32'(mem_wdata), 32'(exp_wd));
      chk("hold_we", 32'(mem_we), 32'(exp_we));
      chk_main(1'($urandom));
   endtask

   initial begin
      reset       = 1'b1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_in     = '0;
      main_in     = '0;
      assert_main = 1'b1;
      mem_rdata   = '0;
      mem_ack     = 1'b0;
      exp_rd      = '0;
      exp_addr    = '0;
      exp_wd      = '0;
      exp_we      = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_out", 32'(main_out), 32'd0);
      step();
      reset = 1'b0;

      // read with 2 wait cycles, accepted on first edge
      xact(0, 16'h1234, 8'h00, 2, 8'hA5);
      chk_main(1'b1);
      chk("rd_a5", 32'(main_out), 32'hA5);
      // zero-wait write leaves read data alone
      xact(1, 16'h00FF, 8'h3C, 0, 8'h77);
      chk_main(1'b1);
      // timeout
      xact(0, 16'h4321, 8'h11, TMO + 5, 8'h99);
      chk_main(1'b1);
      // illegal request
      xact(2, 16'hBEEF, 8'h22, 0, 8'h00);
      // ack exactly at the timeout count
      xact(0, 16'h0F0F, 8'h33, TMO, 8'h5A);
      chk_main(1'b1);

      for (int i = 0; i < 60; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         xact((r < 5) ? 0 : (r < 9) ? 1 : 2,
              16'($urandom), 8'($urandom),
              int'($urandom_range(0, TMO + 3)),
              8'($urandom));
      end

      // make read data non-zero before the reset test
      xact(0, 16'h1111, 8'h00, 1, 8'hC3);
      mem_read = 1'b1;
      addr_in  = 16'h2222;
      step();
      mem_read = 1'b0;
      step();
      step();
      chk("pre_rst_req", 32'(mem_req), 32'd1);
      reset       = 1'b1;
      assert_main = 1'b1;
      #1;
      exp_rd   = '0;
      exp_addr = '0;
      exp_wd   = '0;
      exp_we   = 1'b0;
      chk("arst_req", 32'(mem_req), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      chk("arst_out", 32'(main_out), 32'd0);
      chk("arst_addr", 32'(mem_addr), 32'd0);
      step();
      reset = 1'b0;
      xact(0, 16'h3333, 8'h44, 3, 8'h6E);
      chk_main(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter WIDTH_AX, default 16, address bus width in bits.
REQ-002 Parameter WIDTH_MAIN, default 8, main bus and memory data width in bits.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles to wait for mem_ack; legal range 1..255.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mem_read  in  1  request a memory read; sampled in IDLE only.
REQ-007 mem_write  in  1  request a memory write; sampled in IDLE only.
REQ-008 addr_in  in  WIDTH_AX  address bus value, captured at request acceptance.
REQ-009 main_in  in  WIDTH_MAIN  main bus value, captured as write data at request acceptance.
REQ-010 assert_main  in  1  drive the held read data onto the main bus.
REQ-011 main_out  out  WIDTH_MAIN  read data register when assert_main=1, else all zeros.
REQ-012 main_en  out  1  equals assert_main, combinational; bus driver enable.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse on successful completion.
REQ-015 err  out  1  one-cycle pulse on timeout or illegal request.
REQ-016 mem_addr  out  WIDTH_AX  captured address; stable while mem_req=1.
REQ-017 mem_wdata  out  WIDTH_MAIN  captured write data; stable while mem_req=1.
REQ-018 mem_we  out  1  1 for a write access, 0 for a read; stable while mem_req=1.
REQ-019 mem_req  out  1  access request to external memory.
REQ-020 mem_rdata  in  WIDTH_MAIN  read data, valid in the cycle mem_ack=1.
REQ-021 mem_ack  in  1  access complete; meaningful only while mem_req=1.

Function
REQ-022 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-023 IDLE: exactly one of mem_read/mem_write high at a clock edge -> capture addr_in, main_in and direction, and enter REQ.
REQ-024 IDLE: mem_read and mem_write both high -> no capture and no access; enter ERR.
REQ-025 REQ: mem_req=1; wait counter clears on entry and increments by 1 each cycle without ack.
REQ-026 REQ: mem_ack=1 at an edge -> on a read, load mem_rdata into the read data register; enter DONE.
REQ-027 REQ: counter equals TIMEOUT and mem_ack=0 -> enter ERR; the read data register is unchanged.
REQ-028 Same cycle as a timeout: mem_ack=1 takes priority; the access completes normally.
REQ-029 Minimum latency: request edge -> mem_req high next cycle; ack edge -> done high next cycle.
REQ-030 Back-to-back: done=1 -> zero-wait ack -> mem_read again gives request-to-request spacing of 3 cycles.
REQ-031 DONE: done=1 for exactly one cycle, mem_req=0; unconditional return to IDLE.
REQ-032 ERR: err=1 for exactly one cycle, mem_req=0; unconditional return to IDLE.
REQ-033 mem_read/mem_write outside IDLE SHALL be ignored; no queuing.
REQ-034 mem_addr, mem_wdata and mem_we SHALL hold their last captured values outside REQ.
REQ-035 The read data register SHALL hold its value until the next successful read; writes do not alter it.
REQ-036 mem_ack while mem_req=0 SHALL be ignored.
REQ-037 assert_main is independent of FSM state; main_out reflects the read data register at all times.

Reset
REQ-038 reset=1 SHALL immediately, without a clock, force state IDLE and counter 0.
REQ-039 reset=1 SHALL immediately force the read data register, mem_addr, mem_wdata, mem_we, mem_req, busy, done and err to 0.
REQ-040 reset during REQ SHALL drop mem_req asynchronously; the access is abandoned with no done and no err.
REQ-041 On the first edge after reset deasserts, the block SHALL accept a request.

Verification
REQ-042 Read: addr_in=0x1234, mem_read pulse; ack after 2 wait cycles with mem_rdata=0xA5 -> mem_addr=0x1234, mem_we=0, done pulse; assert_main=1 gives main_out=0xA5, main_en=1.
REQ-043 Write: addr_in=0x00FF, main_in=0x3C, mem_write pulse; zero-wait ack -> mem_we=1, mem_wdata=0x3C, done one cycle after ack; read data register unchanged.
REQ-044 Timeout: TIMEOUT=15, mem_read, mem_ack held 0 -> mem_req high 16 cycles, err pulse, busy low the next cycle, main_out unchanged.
REQ-045 Illegal request: mem_read=mem_write=1 in IDLE -> err pulse, mem_req never asserts.
REQ-046 Ack at the timeout boundary: mem_ack=1 in the cycle the counter equals 15 -> done pulse, no err.
REQ-047 Reset mid-access: reset asserted during REQ -> mem_req=0 immediately, busy=0, done=0, err=0, main_out=0; a new read after release completes normally.
